// File: rtl/csk_pkg.sv
// Shared types and helpers for the pipelined carry-skip adder.
// The stage record here is sized for the default configuration.
package csk_pkg;
  localparam int CSK_WIDTH = 16;
  localparam int CSK_BLK   = 4;
  localparam int CSK_NBLK  = CSK_WIDTH / CSK_BLK;

  function automatic int skip_w(input int nblk);
    return $clog2(nblk + 1);
  endfunction

  localparam int CSK_SKW = skip_w(CSK_NBLK);

  typedef struct packed {
    logic                 vld;
    logic [CSK_WIDTH-1:0] s;
    logic [CSK_WIDTH-1:0] a;
    logic [CSK_WIDTH-1:0] b;
    logic                 c;
    logic                 a_msb;
    logic                 b_msb;
    logic [CSK_SKW-1:0]   skips;
  } csk_stage_t;
endpackage

// File: rtl/csk_pipe_adder_if.sv
// Operand/result handshake bundle for csk_pipe_adder.
interface csk_pipe_adder_if
  import csk_pkg::*;
#(
  parameter int WIDTH = CSK_WIDTH,
  parameter int BLK   = CSK_BLK
);
  localparam int SKW = skip_w(WIDTH / BLK);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [SKW-1:0]   skips;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, skips
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, skips
  );
endinterface

// File: rtl/csk_block.sv
// One BLK-bit carry-skip block: ripple adder plus a skip mux on the carry out.
module csk_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           p
);
  logic [BLK:0]   rc;
  logic [BLK-1:0] x;

  always_comb begin
    x     = a ^ b;
    s     = '0;
    rc    = '0;
    rc[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      s[i]    = x[i] ^ rc[i];
      rc[i+1] = (a[i] & b[i]) | (rc[i] & x[i]);
    end
    p  = &x;
    // When every bit propagates, the block carry-in passes straight through.
    co = p ? ci : rc[BLK];
  end
endmodule

// File: rtl/csk_pipe_adder.sv
// Pipelined carry-skip adder/subtractor: one skip block and one register stage
// per BLK bits, with valid/ready flow control that stalls stage by stage.
module csk_pipe_adder
  import csk_pkg::*;
#(
  parameter int WIDTH = CSK_WIDTH,
  parameter int BLK   = CSK_BLK
) (
  input logic            clk,
  input logic            rst_n,
  csk_pipe_adder_if.slave io
);
  localparam int NBLK = WIDTH / BLK;
  localparam int SKW  = skip_w(NBLK);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             a_msb;
    logic             b_msb;
    logic [SKW-1:0]   skips;
  } stage_t;

  logic [NBLK-1:0] v_q, v_d;
  logic [NBLK:0]   vx, ld_x;
  stage_t          last_q;
  logic            unused_ops;

  // ld_x[k]: stage k loads this cycle; ld_x[NBLK] is the downstream accept.
  always_comb begin
    vx         = {v_q, io.in_valid};
    ld_x       = '0;
    ld_x[NBLK] = io.out_ready;
    for (int k = NBLK - 1; k >= 0; k--) begin
      ld_x[k] = vx[k] && (!v_q[k] || ld_x[k+1]);
    end
    v_d = v_q;
    for (int k = 0; k < NBLK; k++) begin
      if (ld_x[k])        v_d[k] = 1'b1;
      else if (ld_x[k+1]) v_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    stage_t         up, st_d, st_q;
    logic [BLK-1:0] bs;
    logic           bco, bp;

    if (k == 0) begin : g_in
      always_comb begin
        up       = '0;
        up.a     = io.a;
        up.b     = io.op_sub ? ~io.b : io.b;
        up.c     = io.op_sub | io.cin;
        up.a_msb = io.a[WIDTH-1];
        up.b_msb = up.b[WIDTH-1];
      end
    end else begin : g_mid
      assign up = g_stg[k-1].st_q;
    end

    csk_block #(.BLK(BLK)) u_blk (
      .a  (up.a[k*BLK +: BLK]),
      .b  (up.b[k*BLK +: BLK]),
      .ci (up.c),
      .s  (bs),
      .co (bco),
      .p  (bp)
    );

    always_comb begin
      st_d = st_q;
      if (ld_x[k]) begin
        st_d                  = up;
        st_d.s[k*BLK +: BLK]  = bs;
        st_d.c                = bco;
        st_d.skips            = up.skips + SKW'(bp);
      end
    end

    if (k == NBLK - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= '0;
        else        st_q <= st_d;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        st_q <= st_d;
      end
    end
  end

  assign last_q     = g_stg[NBLK-1].st_q;
  assign unused_ops = ^{last_q.a, last_q.b};

  assign io.in_ready  = !v_q[0] || ld_x[1];
  assign io.out_valid = v_q[NBLK-1];
  assign io.sum       = last_q.s;
  assign io.cout      = last_q.c;
  assign io.skips     = last_q.skips;
  assign io.ovf       = (last_q.a_msb == last_q.b_msb) && (last_q.s[WIDTH-1] != last_q.a_msb);
endmodule

// File: tb/tb_csk_pipe_adder.sv
// Directed + stall-stress bench for csk_pipe_adder with a result scoreboard.
module tb_csk_pipe_adder;
  import csk_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csk_pipe_adder_if #(.WIDTH(16), .BLK(4)) bus ();
  csk_pipe_adder #(.WIDTH(16), .BLK(4)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [2:0]  skips;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd_done;

  logic [15:0] bp_a [6] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h00F0, 16'h7FFF, 16'hA5A5};
  logic [15:0] bp_b [6] = '{16'h4321, 16'h0001, 16'h8000, 16'h0F0F, 16'h8001, 16'h5A5A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        r;
    logic [15:0] be;
    logic        c0;
    logic [16:0] t;
    be = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, be} + {16'd0, c0};
    r.sum   = t[15:0];
    r.cout  = t[16];
    r.ovf   = (a[15] == be[15]) && (t[15] != a[15]);
    r.skips = '0;
    for (int k = 0; k < 4; k++) begin
      if (&(a[k*4 +: 4] ^ be[k*4 +: 4])) r.skips = r.skips + 3'd1;
    end
    return r;
  endfunction

  // Scoreboard: every transferred result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL stale_result: observed sum %0h while none expected", bus.sum);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sum",   32'(bus.sum),   32'(e.sum));
        check("cout",  32'(bus.cout),  32'(e.cout));
        check("ovf",   32'(bus.ovf),   32'(e.ovf));
        check("skips", 32'(bus.skips), 32'(e.skips));
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input exp_t e);
    int w;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.op_sub   = sub;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("in_ready_at_accept", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
    send(a, b, cin, sub, model(a, b, cin, sub));
  endtask

  task automatic check_latency(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || bus.out_valid) && w < 60) begin
      w++;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;
    rnd_done      = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_skips",     32'(bus.skips),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Test-plan vectors with hand-derived results.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0100, cout: 1'b0, ovf: 1'b0, skips: 3'd1});
    check_latency("lat_add");
    drain();
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, skips: 3'd4});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1, skips: 3'd2});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1, skips: 3'd2});
    drain();

    // Backpressure: pipeline fills to 4 beats, then in_ready must drop.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_m(bp_a[i], bp_b[i], 1'b0, i[0]);
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (bus.in_ready && w < 50) begin
          w++;
          @(negedge clk);
        end
        check("bp_in_ready_low",   32'(bus.in_ready),  32'd0);
        check("bp_held_beats",     32'(sb.size()),     32'd4);
        check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send_m(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset with three beats in flight.
    send_m(16'h0101, 16'h0202, 1'b0, 1'b0);
    send_m(16'hF00F, 16'h0FF0, 1'b1, 1'b0);
    send_m(16'h1000, 16'h2000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum",       32'(bus.sum),       32'd0);
    check("mid_rst_skips",     32'(bus.skips),     32'd0);
    check("mid_rst_cout",      32'(bus.cout),      32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(16'd3, 16'd5, 1'b0, 1'b0, '{sum: 16'd8, cout: 1'b0, ovf: 1'b0, skips: 3'd0});
    check_latency("lat_post_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csk_pipe_adder.md
# csk_pipe_adder

Parametrised, pipelined carry-skip adder/subtractor. It generalises the fixed 8-bit, two-block carry-skip adder to WIDTH bits split into WIDTH/BLK skip blocks, with one pipeline register per block and a valid/ready handshake on both sides. It sits in the arithmetic datapath as a full-throughput add/sub unit. It also reports signed overflow and a per-result count of skipped blocks, for carry-path characterisation.

## Interface
- WIDTH, 16: operand/sum width; must be a multiple of BLK, and ≥ BLK.
- BLK, 4: bits per carry-skip block; NBLK = WIDTH/BLK is both the block count and the pipeline depth.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a, b  in  WIDTH  operands, unsigned or two's complement.
- cin  in  1  carry in; used when op_sub=0.
- op_sub  in  1  1: a − b, computed as a + ~b + 1; cin is ignored.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB (for subtraction, 1 = no borrow).
- ovf  out  1  signed overflow.
- skips  out  $clog2(NBLK+1)  number of blocks whose carry took the skip path.

## Operation
- A beat is transferred when in_valid && in_ready. A result is transferred when out_valid && out_ready.
- Operand preparation at acceptance:
  - b_eff = op_sub ? ~b : b
  - c0 = op_sub ? 1 : cin
- Stage k (k = 0..NBLK−1) holds:
  - a valid bit;
  - the sum bits already computed;
  - the remaining operand slices of a and b_eff;
  - the carry into block k;
  - the MSB sign bits a[W−1] and b_eff[W−1];
  - the running skip count.
- Each block computes, combinationally:
  - ripple sum and ripple carry over BLK full-adder cells;
  - propagate P = AND of (a_i ^ b_i) over the block;
  - carry out = P ? block carry-in : ripple carry;
  - skips increments when P = 1.
- Block k's logic sits between stage register k−1 (or the input, for k = 0) and stage register k. The last stage register drives the outputs directly.
- Stage k loads when its upstream is valid and (!v[k] || stage k+1 loads). The last stage uses out_ready in place of "stage k+1 loads".
- in_ready = !v[0] || stage 1 loads. This is combinational from out_ready.
- Output outputs:
  - out_valid = v[NBLK−1];
  - ovf = (a_msb == b_eff_msb) && (sum[W−1] != a_msb).
- A stalled stage holds all of its contents. Results leave in acceptance order, with no loss and no duplication.
- Reset (asynchronous, any cycle, including mid-stream):
  - all valid bits clear immediately, so out_valid = 0 and in-flight beats are discarded;
  - sum, cout, ovf and skips reset to 0;
  - in_ready = 1 one cycle after rst_n deasserts.
- Datapath registers other than the valid bits and the output stage need no reset.

## Timing
- Latency is NBLK cycles from acceptance to out_valid when there are no stalls (4 cycles at defaults).
- Throughput is one beat per cycle when out_ready is held at 1.
- Capacity is NBLK beats. With out_ready = 0 and the pipeline full, in_ready = 0.
- A simultaneous accept and emit when full is legal and keeps the pipeline full.
- The critical path is one BLK-bit ripple plus one skip mux per stage.
- The WIDTH == BLK degenerate case is a single stage with 1-cycle latency.

## Structure
- Package csk_pkg holds:
  - the stage record typedef (valid, partial sum, remaining operands, carry, sign bits, skip count), parametrised through localparams derived from WIDTH and BLK;
  - a function computing the skip-count width.
- Sub-module csk_block (parameter BLK) is purely combinational:
  - inputs: a, b, ci;
  - outputs: s, co, p.
- csk_pipe_adder instantiates NBLK copies of csk_block and owns the stage registers and the handshake.

## Test plan
Defaults apply (WIDTH = 16, BLK = 4).
- Add 0x00FF + 0x0001, cin = 0 -> after 4 cycles: sum 0x0100, cout 0, ovf 0, skips 1.
- Add 0xFFFF + 0x0000, cin = 1 -> sum 0x0000, cout 1, ovf 0, skips 4 (full skip chain).
- Sub 0x8000 − 0x0001 -> sum 0x7FFF, cout 1, ovf 1, skips 2.
- Add 0x7FFF + 0x0001, cin = 0 -> sum 0x8000, cout 0, ovf 1, skips 2.
- Backpressure: 6 back-to-back beats with out_ready = 0 for 4 cycles mid-stream:
  - in_ready drops once 4 beats are held;
  - all 6 results appear in order, none lost or duplicated;
  - checked against a reference model.
- Reset with 3 beats in flight:
  - out_valid is 0 in the same cycle rst_n falls;
  - no stale results appear after release;
  - a fresh beat 3 + 5 = 8 emerges 4 cycles after acceptance.
